branch_ctrl: RTL and testbench
==============================

# branch_ctrl

Sequencing controller for the 16-entry branch prediction table. After reset it sweeps and invalidates every table line, then each cycle resolves the `beq` leaving decode against its fetch-time prediction. It drives the table's tag/prediction write ports, selects the next fetch PC, and issues a one-cycle flush/redirect on mispredict. It sits between fetch (table lookup), decode (branch resolution) and the PC register.

## Interface
- `ENTRIES`, 16, table lines (power of two)
- `IDX_W`, 4, log2(ENTRIES); index = pc4[IDX_W+1:2]
- `TAG_W`, 26, 32-IDX_W-2
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `f_pc4`  in  32  PC+4 of fetch
- `f_hit`, `f_pred`  in  1  table hit / prediction for `f_pc4`
- `f_dest`  in  32  table destination for `f_pc4`
- `npc`  out  32  next fetch PC
- `busy`  out  1  init sweep active; fetch stalls
- `d_valid`, `d_is_beq`  in  1  decode slot valid / holds a beq
- `d_pc4`, `d_target`  in  32  branch PC+4 / computed target
- `d_taken`  in  1  resolved outcome
- `d_was_hit`, `d_was_pred`  in  1  hit/pred carried from fetch
- `wr_tag`, `wr_pred`  out  1  table WRt / WRp
- `wr_pc4`, `wr_dest`  out  32  table PC4d / BdestIN
- `wr_pin`  out  1  table Pin
- `flush`  out  1  squash fetch/decode stages
- `redirect_pc`  out  32  correct PC during `flush`

## Operation
- States: INIT, RUN, SQUASH. Reset enters INIT with idx=0.
- INIT:
  - Each cycle registers `wr_tag`=`wr_pred`=1, `wr_pc4`={all-ones tag, idx, 2'b00}, `wr_dest`=0, `wr_pin`=0; idx++.
  - After idx=ENTRIES-1, go to RUN.
  - `busy`=1; decode inputs ignored.
- RUN: a beq resolves when `d_valid & d_is_beq`.
  - predicted taken pt = `d_was_hit & d_was_pred`; mispredict = pt != `d_taken`.
  - Miss & taken: wr_tag=1, wr_pred=1, wr_pin=1, wr_dest=`d_target`, wr_pc4=`d_pc4`.
  - Miss & not taken: no write.
  - Hit: wr_pred=1, wr_pin=`d_taken` only when it differs from `d_was_pred`.
  - Mispredict: flush=1, redirect_pc = `d_taken` ? `d_target` : `d_pc4`; next state SQUASH.
- SQUASH: one cycle; `d_valid` ignored (wrong path); write strobes 0; return to RUN.
- `npc` (combinational):
  - `flush` → `redirect_pc`
  - else `f_hit & f_pred` → `f_dest`
  - else `f_pc4`
  - In INIT, `npc` = `f_pc4`.
- Non-beq or invalid decode slot: no write, no flush.

## Timing
- Reset values:
  - state INIT, idx 0, `busy`=1
  - `flush`=0, `redirect_pc`=0
  - `wr_tag`=`wr_pred`=`wr_pin`=0, `wr_pc4`=`wr_dest`=0
- All `wr_*`, `flush` and `redirect_pc` are registered.
- Branch resolved in cycle N:
  - strobes, flush and redirect visible in N+1
  - table updates at edge ending N+1
  - `npc`=redirect_pc in N+1
- `flush` is exactly one cycle. A mispredict cannot occur in SQUASH, so flushes are never back-to-back.
- INIT lasts exactly ENTRIES cycles after reset release; `busy` falls in cycle ENTRIES.
- `rst` mid-INIT or mid-RUN: immediate return to INIT, idx 0; pending strobes/flush cleared asynchronously.

## Configuration
- `BCTRL_HYST_EN` defined:
  - Controller holds a 2-bit saturating counter per line, reset to 01.
  - Hit: counter ±1 by `d_taken`.
  - Miss & taken insert: counter set to 10.
  - `wr_pred`/`wr_pin`=counter MSB, written only when the MSB changes.
  - INIT sweep also resets counters.
  - Flush logic unchanged.
- Undefined: 1-bit policy above; no counter storage.

## Structure
- Shared package `bctrl_pkg`:
  - state encoding (INIT/RUN/SQUASH)
  - `ENTRIES`/`IDX_W`/`TAG_W` defaults
  - invalid-tag constant (all ones)
  - index-extract helper
- One natural sub-module `bctrl_hyst`: counter array plus next-MSB logic, instantiated only under `BCTRL_HYST_EN`.

## Test plan
- Reset release → `busy` high 16 cycles; `wr_tag`/`wr_pred` pulses with `wr_pc4`=0xFFFFFFC0..0xFFFFFFFC step 4, `wr_pin`=0; `busy` low at cycle 16.
- RUN, beq `d_pc4`=0x40, `d_target`=0x100, taken, miss → next cycle `flush`=1, `redirect_pc`=0x100, `npc`=0x100, wr_tag=wr_pred=1, wr_pc4=0x40, wr_dest=0x100, wr_pin=1.
- Hit pred=1, `d_taken`=0, `d_pc4`=0x80 → flush, redirect 0x80; no macro: wr_pred=1, wr_pin=0; with macro (counter 11→10): no write.
- Mispredict in N, valid mispredicting beq in N+1 → ignored: no flush or write in N+2.
- Fetch `f_hit`=1, `f_pred`=1, `f_dest`=0x200, no flush → `npc`=0x200; `f_pred`=0 → `npc`=`f_pc4`.
- `rst` pulse at init idx 7 → strobes drop, sweep restarts at idx 0, 16 full cycles.

Source files
------------

// File: rtl/bctrl_pkg.sv
// bctrl_pkg: shared definitions for the branch prediction table controller.
//   - table geometry defaults (ENTRIES, IDX_W, TAG_W)
//   - controller state encoding (INIT / RUN / SQUASH)
//   - invalid-tag constant used by the post-reset sweep
//   - helper that extracts the table index from a PC+4 value
package bctrl_pkg;

   localparam int ENTRIES = 16;
   localparam int IDX_W   = 4;              // log2(ENTRIES)
   localparam int TAG_W   = 32 - IDX_W - 2;

   // An all-ones tag never matches a real fetch PC, so it marks a line invalid.
   localparam logic [TAG_W-1:0] TAG_INVALID = '1;

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_SQUASH = 2'd2
   } state_t;

   function automatic logic [IDX_W-1:0] idx_of(input logic [31:0] pc4);
      return pc4[IDX_W+1:2];
   endfunction

endpackage

// File: rtl/bctrl_hyst.sv
// bctrl_hyst: per-line 2-bit saturating counters for hysteresis prediction.
// Only instantiated when BCTRL_HYST_EN is defined.
// Ports:
//   clk, rst          clock / asynchronous active-high reset (counters -> 01)
//   init_we_i         sweep write: reset counter at init_idx_i to 01
//   init_idx_i        line being swept
//   upd_en_i          a beq resolves this cycle
//   upd_idx_i         line of the resolving beq
//   upd_hit_i         resolving beq hit in the table
//   upd_taken_i       resolved outcome
//   msb_new_o         counter MSB after the update (new prediction bit)
//   msb_chg_o         MSB differs from the current one (table write needed)
module bctrl_hyst
   import bctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             init_we_i,
   input  logic [IDX_W-1:0] init_idx_i,
   input  logic             upd_en_i,
   input  logic [IDX_W-1:0] upd_idx_i,
   input  logic             upd_hit_i,
   input  logic             upd_taken_i,
   output logic             msb_new_o,
   output logic             msb_chg_o
);

   logic [1:0] cnt_q [ENTRIES];
   logic [1:0] cur;
   logic [1:0] cnt_d;

   always_comb begin
      cur   = cnt_q[upd_idx_i];
      cnt_d = cur;
      if (upd_hit_i) begin
         if (upd_taken_i) cnt_d = (cur == 2'b11) ? 2'b11 : cur + 2'b01;
         else             cnt_d = (cur == 2'b00) ? 2'b00 : cur - 2'b01;
      end else begin
         // A fresh insertion starts weakly taken.
         cnt_d = 2'b10;
      end
   end

   assign msb_new_o = cnt_d[1];
   assign msb_chg_o = cnt_d[1] != cur[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= 2'b01;
      end else if (init_we_i) begin
         cnt_q[init_idx_i] <= 2'b01;
      end else if (upd_en_i && (upd_hit_i || upd_taken_i)) begin
         // Misses that fall through are not inserted, so their line is left alone.
         cnt_q[upd_idx_i] <= cnt_d;
      end
   end

endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: sequencing controller for the branch prediction table.
// After reset it sweeps every line invalid, then resolves the beq in decode
// against its fetch-time prediction, writes the table and flushes on mispredict.
// Optional feature macro: BCTRL_HYST_EN (2-bit hysteresis counters per line).
// Ports:
//   clk, rst                   clock / asynchronous active-high reset
//   f_pc4, f_hit, f_pred,      fetch-side table lookup result
//   f_dest
//   npc                        next fetch PC (combinational)
//   busy                       init sweep in progress, fetch stalls
//   d_valid, d_is_beq, d_pc4,  decode-side branch resolution
//   d_target, d_taken,
//   d_was_hit, d_was_pred
//   wr_tag, wr_pred, wr_pc4,   registered table write port
//   wr_dest, wr_pin
//   flush, redirect_pc         one-cycle squash and correct PC
//   dbg_state                  current controller state (bctrl_pkg::state_t)
module branch_ctrl
   import bctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] f_pc4,
   input  logic        f_hit,
   input  logic        f_pred,
   input  logic [31:0] f_dest,
   output logic [31:0] npc,
   output logic        busy,
   input  logic        d_valid,
   input  logic        d_is_beq,
   input  logic [31:0] d_pc4,
   input  logic [31:0] d_target,
   input  logic        d_taken,
   input  logic        d_was_hit,
   input  logic        d_was_pred,
   output logic        wr_tag,
   output logic        wr_pred,
   output logic [31:0] wr_pc4,
   output logic [31:0] wr_dest,
   output logic        wr_pin,
   output logic        flush,
   output logic [31:0] redirect_pc,
   output logic [1:0]  dbg_state
);

   state_t           state_q;
   logic [IDX_W-1:0] idx_q;
   logic             wr_tag_q, wr_pred_q, wr_pin_q, flush_q;
   logic [31:0]      wr_pc4_q, wr_dest_q, redirect_q;

   // Decode handshake: the slot carries a branch to resolve only in a cycle
   // where d_valid & d_is_beq is high in RUN; there is no back-pressure, the
   // controller consumes it in that same cycle. In INIT and SQUASH the slot is
   // ignored (table not ready / wrong-path instruction).
   logic resolve, pred_taken, mispredict;
   logic hit_wr, hit_pin;

   assign resolve    = (state_q == ST_RUN) && d_valid && d_is_beq;
   assign pred_taken = d_was_hit && d_was_pred;
   assign mispredict = pred_taken != d_taken;

`ifdef BCTRL_HYST_EN
   bctrl_hyst u_hyst (
      .clk         (clk),
      .rst         (rst),
      .init_we_i   (state_q == ST_INIT),
      .init_idx_i  (idx_q),
      .upd_en_i    (resolve),
      .upd_idx_i   (idx_of(d_pc4)),
      .upd_hit_i   (d_was_hit),
      .upd_taken_i (d_taken),
      .msb_new_o   (hit_pin),
      .msb_chg_o   (hit_wr)
   );
`else
   // 1-bit policy: rewrite the prediction bit only when the outcome disagrees.
   assign hit_wr  = d_taken != d_was_pred;
   assign hit_pin = d_taken;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_INIT;
         idx_q      <= '0;
         wr_tag_q   <= 1'b0;
         wr_pred_q  <= 1'b0;
         wr_pin_q   <= 1'b0;
         wr_pc4_q   <= '0;
         wr_dest_q  <= '0;
         flush_q    <= 1'b0;
         redirect_q <= '0;
      end else begin
         case (state_q)
            ST_INIT: begin
               wr_tag_q  <= 1'b1;
               wr_pred_q <= 1'b1;
               wr_pin_q  <= 1'b0;
               wr_pc4_q  <= {TAG_INVALID, idx_q, 2'b00};
               wr_dest_q <= '0;
               flush_q   <= 1'b0;
               idx_q     <= idx_q + IDX_W'(1);
               if (idx_q == IDX_W'(ENTRIES - 1)) state_q <= ST_RUN;
            end
            ST_RUN: begin
               wr_tag_q  <= 1'b0;
               wr_pred_q <= 1'b0;
               wr_pin_q  <= 1'b0;
               flush_q   <= 1'b0;
               if (resolve) begin
                  if (!d_was_hit) begin
                     if (d_taken) begin
                        wr_tag_q  <= 1'b1;
                        wr_pred_q <= 1'b1;
                        wr_pin_q  <= 1'b1;
                        wr_pc4_q  <= d_pc4;
                        wr_dest_q <= d_target;
                     end
                  end else if (hit_wr) begin
                     wr_pred_q <= 1'b1;
                     wr_pin_q  <= hit_pin;
                     wr_pc4_q  <= d_pc4;
                     wr_dest_q <= d_target;
                  end
                  if (mispredict) begin
                     flush_q    <= 1'b1;
                     redirect_q <= d_taken ? d_target : d_pc4;
                     state_q    <= ST_SQUASH;
                  end
               end
            end
            ST_SQUASH: begin
               wr_tag_q  <= 1'b0;
               wr_pred_q <= 1'b0;
               wr_pin_q  <= 1'b0;
               flush_q   <= 1'b0;
               state_q   <= ST_RUN;
            end
            default: begin
               state_q <= ST_INIT;
               idx_q   <= '0;
            end
         endcase
      end
   end

   assign wr_tag      = wr_tag_q;
   assign wr_pred     = wr_pred_q;
   assign wr_pin      = wr_pin_q;
   assign wr_pc4      = wr_pc4_q;
   assign wr_dest     = wr_dest_q;
   assign flush       = flush_q;
   assign redirect_pc = redirect_q;
   assign busy        = (state_q == ST_INIT);
   assign dbg_state   = state_q;

   // Table predictions are not trusted until the sweep has finished.
   always_comb begin
      npc = f_pc4;
      if (flush_q)                                 npc = redirect_q;
      else if (state_q != ST_INIT && f_hit && f_pred) npc = f_dest;
   end

endmodule

// File: tb/tb_branch_ctrl.sv
module tb_branch_ctrl;
   import bctrl_pkg::*;

   // Expected output event: {chk_addr, tag, pred, pin, flush, pc4, dest, redirect}
   localparam int EW = 101;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] f_pc4 = '0, f_dest = '0;
   logic        f_hit = 1'b0, f_pred = 1'b0;
   logic [31:0] npc;
   logic        busy;
   logic        d_valid = 1'b0, d_is_beq = 1'b0, d_taken = 1'b0;
   logic        d_was_hit = 1'b0, d_was_pred = 1'b0;
   logic [31:0] d_pc4 = '0, d_target = '0;
   logic        wr_tag, wr_pred, wr_pin, flush;
   logic [31:0] wr_pc4, wr_dest, redirect_pc;
   logic [1:0]  dbg_state;

   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] mon_e;
   int checks = 0;
   int errors = 0;

`ifdef BCTRL_HYST_EN
   localparam bit HYST = 1'b1;
`else
   localparam bit HYST = 1'b0;
`endif

   branch_ctrl dut (
      .clk(clk), .rst(rst),
      .f_pc4(f_pc4), .f_hit(f_hit), .f_pred(f_pred), .f_dest(f_dest),
      .npc(npc), .busy(busy),
      .d_valid(d_valid), .d_is_beq(d_is_beq), .d_pc4(d_pc4), .d_target(d_target),
      .d_taken(d_taken), .d_was_hit(d_was_hit), .d_was_pred(d_was_pred),
      .wr_tag(wr_tag), .wr_pred(wr_pred), .wr_pc4(wr_pc4), .wr_dest(wr_dest),
      .wr_pin(wr_pin), .flush(flush), .redirect_pc(redirect_pc),
      .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [EW-1:0] ev(input bit chk_addr, input bit tag, input bit pred,
                                        input bit pin, input bit fl, input logic [31:0] pc4,
                                        input logic [31:0] dest, input logic [31:0] redir);
      return {chk_addr, tag, pred, pin, fl, pc4, dest, redir};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive_beq(input logic [31:0] pc4, input logic [31:0] tgt, input bit taken,
                            input bit was_hit, input bit was_pred);
      d_valid    = 1'b1;
      d_is_beq   = 1'b1;
      d_pc4      = pc4;
      d_target   = tgt;
      d_taken    = taken;
      d_was_hit  = was_hit;
      d_was_pred = was_pred;
   endtask

   task automatic idle_decode();
      d_valid  = 1'b0;
      d_is_beq = 1'b0;
   endtask

   // Full post-reset sweep; called right after rst is released.
   task automatic init_sweep();
      logic [31:0] base;
      base = 32'hFFFF_FFC0;
      for (int i = 0; i < 16; i++) exp_q.push_back(ev(1, 1, 1, 0, 0, base + 32'(4 * i), 32'h0, 32'h0));
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("busy_init_c%0d", i), {31'd0, busy}, 32'd1);
         tick();
      end
      chk("busy_low_c16", {31'd0, busy}, 32'd0);
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (!rst && (wr_tag || wr_pred || flush)) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event tag=%0b pred=%0b flush=%0b pc4=%h required=no_event",
                     wr_tag, wr_pred, flush, wr_pc4);
         end else begin
            mon_e = exp_q.pop_front();
            chk("strobes_tag_pred_flush", {29'd0, wr_tag, wr_pred, flush},
                {29'd0, mon_e[99], mon_e[98], mon_e[96]});
            if (mon_e[98]) chk("wr_pin", {31'd0, wr_pin}, {31'd0, mon_e[97]});
            if (mon_e[100]) begin
               chk("wr_pc4", wr_pc4, mon_e[95:64]);
               chk("wr_dest", wr_dest, mon_e[63:32]);
            end
            if (mon_e[96]) begin
               chk("redirect_pc", redirect_pc, mon_e[31:0]);
               chk("npc_on_flush", npc, mon_e[31:0]);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      f_pc4 = 32'h1234; f_hit = 1'b1; f_pred = 1'b1; f_dest = 32'h200;
      tick();
      tick();
      // Reset state
      chk("rst_busy", {31'd0, busy}, 32'd1);
      chk("rst_state", {30'd0, dbg_state}, {30'd0, ST_INIT});
      chk("rst_strobes", {29'd0, wr_tag, wr_pred, wr_pin}, 32'd0);
      chk("rst_flush", {31'd0, flush}, 32'd0);
      chk("rst_redirect", redirect_pc, 32'h0);
      chk("rst_wr_pc4", wr_pc4, 32'h0);
      chk("rst_wr_dest", wr_dest, 32'h0);
      chk("npc_in_init", npc, 32'h1234);

      rst = 1'b0;
      // Decode is ignored during the sweep even with a mispredicting beq present.
      drive_beq(32'h44, 32'h500, 1, 0, 0);
      init_sweep();
      idle_decode();

      // Fetch-side next PC selection
      chk("npc_pred_taken", npc, 32'h200);
      f_pred = 1'b0; #1;
      chk("npc_pred_not_taken", npc, 32'h1234);
      f_hit = 1'b0; f_pred = 1'b1; #1;
      chk("npc_miss", npc, 32'h1234);
      f_hit = 1'b1; f_pred = 1'b1; f_dest = 32'h200;

      // Miss & taken: insert + flush to target
      drive_beq(32'h40, 32'h100, 1, 0, 0);
      exp_q.push_back(ev(1, 1, 1, 1, 1, 32'h40, 32'h100, 32'h100));
      tick(); idle_decode(); tick();

      // Correctly predicted taken hit (counter 10 -> 11 with hysteresis): no event
      drive_beq(32'h80, 32'h900, 1, 1, 1);
      tick();
      // Hit predicted taken, actually not taken: flush to fall-through
      drive_beq(32'h80, 32'h900, 0, 1, 1);
      exp_q.push_back(ev(0, 0, !HYST, 0, 1, 32'h0, 32'h0, 32'h80));
      tick(); idle_decode(); tick();

      // Mispredict in N, another mispredicting beq in N+1 must be squashed
      drive_beq(32'hC0, 32'h300, 1, 1, 0);
      exp_q.push_back(ev(0, 0, !HYST, 1, 1, 32'h0, 32'h0, 32'h300));
      tick();
      drive_beq(32'h44, 32'h500, 1, 0, 0);
      tick(); idle_decode(); tick(); tick();

      // Slots that must produce nothing
      drive_beq(32'h50, 32'h600, 1, 0, 0); d_is_beq = 1'b0; tick();
      drive_beq(32'h50, 32'h600, 1, 0, 0); d_valid = 1'b0; tick();
      drive_beq(32'h50, 32'h600, 0, 0, 0); tick();
      idle_decode(); tick();
      chk("no_flush_quiet", {31'd0, flush}, 32'd0);
      chk("no_write_quiet", {30'd0, wr_tag, wr_pred}, 32'd0);

      // Fresh line (counter 01): taken flips prediction, then not-taken flips it back
      drive_beq(32'h48, 32'h600, 1, 1, 0);
      exp_q.push_back(ev(0, 0, 1, 1, 1, 32'h0, 32'h0, 32'h600));
      tick(); idle_decode(); tick();
      drive_beq(32'h48, 32'h600, 0, 1, 1);
      exp_q.push_back(ev(0, 0, 1, 0, 1, 32'h0, 32'h0, 32'h48));
      tick(); idle_decode(); tick();

      // Reset mid-RUN while a flush is pending: cleared asynchronously
      drive_beq(32'h4C, 32'h700, 1, 0, 0);
      tick();
      rst = 1'b1; #1;
      idle_decode();
      chk("midrun_rst_flush", {31'd0, flush}, 32'd0);
      chk("midrun_rst_redirect", redirect_pc, 32'h0);
      chk("midrun_rst_wr", {30'd0, wr_tag, wr_pred}, 32'd0);
      chk("midrun_rst_busy", {31'd0, busy}, 32'd1);
      tick();
      rst = 1'b0;

      // Partial sweep, reset at idx 7, then a full restart
      for (int i = 0; i < 6; i++)
         exp_q.push_back(ev(1, 1, 1, 0, 0, 32'hFFFF_FFC0 + 32'(4 * i), 32'h0, 32'h0));
      for (int i = 0; i < 7; i++) tick();
      rst = 1'b1; #1;
      chk("midinit_rst_wr", {30'd0, wr_tag, wr_pred}, 32'd0);
      chk("midinit_rst_busy", {31'd0, busy}, 32'd1);
      tick();
      rst = 1'b0;
      init_sweep();

      tick(); tick();
      chk("scoreboard_drained", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
